// File: rtl/wb_to_avalon_bridge.sv
// Classic Wishbone slave to single-beat Avalon-MM master bridge.
// One transfer in flight; the Avalon command and Wishbone response are registered, and each transfer has a timeout.
module wb_to_avalon_bridge #(
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 32,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   wbs_adr_i,
  input  logic [DW-1:0]   wbs_dat_i,
  input  logic [DW/8-1:0] wbs_sel_i,
  input  logic            wbs_we_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_stb_i,
  input  logic [2:0]      wbs_cti_i,
  input  logic [1:0]      wbs_bte_i,
  output logic [DW-1:0]   wbs_dat_o,
  output logic            wbs_ack_o,
  output logic            wbs_err_o,
  output logic            wbs_rty_o,
  output logic [AW-1:0]   avm_address_o,
  output logic [DW/8-1:0] avm_byteenable_o,
  output logic            avm_read_o,
  output logic            avm_write_o,
  output logic [DW-1:0]   avm_writedata_o,
  output logic [7:0]      avm_burstcount_o,
  input  logic [DW-1:0]   avm_readdata_i,
  input  logic            avm_waitrequest_i,
  input  logic            avm_readdatavalid_i
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, WRITE, READ_CMD, READ_WAIT, DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_abort, w_abort_nxt;
  logic [AW-1:0]   r_adr, w_adr_nxt;
  logic [SW-1:0]   r_sel, w_sel_nxt;
  logic [DW-1:0]   r_wdat, w_wdat_nxt;
  logic [DW-1:0]   r_rdat, w_rdat_nxt;
  logic            r_ack, w_ack_nxt;
  logic            r_err, w_err_nxt;
  logic            r_read, r_write;
  logic            w_busy, w_abort, w_tmo;
  logic            w_unused;

  assign w_busy   = (r_state == WRITE) || (r_state == READ_CMD) || (r_state == READ_WAIT);
  // Once the master drops cyc the transfer still runs to completion, but silently.
  assign w_abort  = r_abort | ~wbs_cyc_i;
  assign w_tmo    = (r_cnt == TMO_LAST);
  assign w_unused = ^{wbs_cti_i, wbs_bte_i};

  // Next-state, capture and response flags
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_abort_nxt = r_abort;
    w_adr_nxt   = r_adr;
    w_sel_nxt   = r_sel;
    w_wdat_nxt  = r_wdat;
    w_rdat_nxt  = r_rdat;
    w_ack_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          w_adr_nxt   = wbs_adr_i;
          w_sel_nxt   = wbs_sel_i;
          w_wdat_nxt  = wbs_dat_i;
          w_cnt_nxt   = '0;
          w_abort_nxt = 1'b0;
          w_state_nxt = wbs_we_i ? WRITE : READ_CMD;
        end
      end
      WRITE: begin
        if (!avm_waitrequest_i) begin
          w_state_nxt = DONE;
          w_ack_nxt   = ~w_abort;
        end else if (w_tmo) begin
          w_state_nxt = DONE;
          w_err_nxt   = ~w_abort;
        end
      end
      READ_CMD: begin
        if (!avm_waitrequest_i && avm_readdatavalid_i) begin
          w_rdat_nxt  = avm_readdata_i;
          w_state_nxt = DONE;
          w_ack_nxt   = ~w_abort;
        end else if (w_tmo) begin
          w_state_nxt = DONE;
          w_err_nxt   = ~w_abort;
        end else if (!avm_waitrequest_i) begin
          w_state_nxt = READ_WAIT;
        end
      end
      READ_WAIT: begin
        if (avm_readdatavalid_i) begin
          w_rdat_nxt  = avm_readdata_i;
          w_state_nxt = DONE;
          w_ack_nxt   = ~w_abort;
        end else if (w_tmo) begin
          w_state_nxt = DONE;
          w_err_nxt   = ~w_abort;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (w_busy) begin
      w_cnt_nxt   = r_cnt + CW'(1);
      w_abort_nxt = w_abort;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_abort <= 1'b0;
      r_adr   <= '0;
      r_sel   <= '0;
      r_wdat  <= '0;
      r_rdat  <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_read  <= 1'b0;
      r_write <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_abort <= w_abort_nxt;
      r_adr   <= w_adr_nxt;
      r_sel   <= w_sel_nxt;
      r_wdat  <= w_wdat_nxt;
      r_rdat  <= w_rdat_nxt;
      r_ack   <= w_ack_nxt;
      r_err   <= w_err_nxt;
      r_read  <= (w_state_nxt == READ_CMD);
      r_write <= (w_state_nxt == WRITE);
    end
  end

  assign wbs_dat_o        = r_rdat;
  assign wbs_ack_o        = r_ack;
  assign wbs_err_o        = r_err;
  assign wbs_rty_o        = 1'b0;
  assign avm_address_o    = r_adr;
  assign avm_byteenable_o = r_sel;
  assign avm_read_o       = r_read;
  assign avm_write_o      = r_write;
  assign avm_writedata_o  = r_wdat;
  assign avm_burstcount_o = 8'd1;

endmodule

// File: tb/tb_wb_to_avalon_bridge.sv
// Self-checking bench for wb_to_avalon_bridge: vector table driven through a reactive Avalon slave,
// with a response scoreboard plus hand sequences for stray readdatavalid and mid-transfer reset.
module tb_wb_to_avalon_bridge;

  localparam int unsigned TMO = 16;

  logic        clk, rst;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic [3:0]  wbs_sel_i;
  logic        wbs_we_i, wbs_cyc_i, wbs_stb_i;
  logic [2:0]  wbs_cti_i;
  logic [1:0]  wbs_bte_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o, wbs_err_o, wbs_rty_o;
  logic [31:0] avm_address_o;
  logic [3:0]  avm_byteenable_o;
  logic        avm_read_o, avm_write_o;
  logic [31:0] avm_writedata_o;
  logic [7:0]  avm_burstcount_o;
  logic [31:0] avm_readdata_i;
  logic        avm_waitrequest_i, avm_readdatavalid_i;

  wb_to_avalon_bridge #(.DW(32), .AW(32), .TIMEOUT(TMO)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .wbs_adr_i           (wbs_adr_i),
    .wbs_dat_i           (wbs_dat_i),
    .wbs_sel_i           (wbs_sel_i),
    .wbs_we_i            (wbs_we_i),
    .wbs_cyc_i           (wbs_cyc_i),
    .wbs_stb_i           (wbs_stb_i),
    .wbs_cti_i           (wbs_cti_i),
    .wbs_bte_i           (wbs_bte_i),
    .wbs_dat_o           (wbs_dat_o),
    .wbs_ack_o           (wbs_ack_o),
    .wbs_err_o           (wbs_err_o),
    .wbs_rty_o           (wbs_rty_o),
    .avm_address_o       (avm_address_o),
    .avm_byteenable_o    (avm_byteenable_o),
    .avm_read_o          (avm_read_o),
    .avm_write_o         (avm_write_o),
    .avm_writedata_o     (avm_writedata_o),
    .avm_burstcount_o    (avm_burstcount_o),
    .avm_readdata_i      (avm_readdata_i),
    .avm_waitrequest_i   (avm_waitrequest_i),
    .avm_readdatavalid_i (avm_readdatavalid_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    int          wait_n;   // command cycles with waitrequest held
    int          rdv_d;    // readdatavalid delay after accept, 0 = accept cycle
    logic [31:0] rdata;
    int          abort_n;  // cycle at which cyc drops, 0 = never
    bit          exp_ack;
    bit          exp_err;
    logic [31:0] exp_dat;
    int          exp_lat;  // cycles from stb drive to response
    int          exp_k;    // cycles avm_read_o/avm_write_o is high
  } vec_t;

  typedef struct {
    bit          ack;
    bit          err;
    logic [31:0] dat;
  } resp_t;

  resp_t sb_q[$];
  vec_t  vecs[13];
  vec_t  vpost;
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every ack/err pops the response expected when its stimulus was driven.
  always @(negedge clk) begin
    resp_t e;
    if (!rst && (wbs_ack_o || wbs_err_o)) begin
      check_eq("ack_err_exclusive", 32'(wbs_ack_o & wbs_err_o), 32'd0);
      if (sb_q.size() == 0) begin
        check_eq("unexpected_response", {30'd0, wbs_err_o, wbs_ack_o}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("resp_ack", 32'(wbs_ack_o), 32'(e.ack));
        check_eq("resp_err", 32'(wbs_err_o), 32'(e.err));
        check_eq("resp_dat", wbs_dat_o, e.dat);
      end
    end
  end

  // Drives one Wishbone transfer and plays the Avalon slave cycle by cycle.
  task automatic run_txn(input vec_t v);
    int k, since, resp_n;
    bit got;
    k = 0; since = -1; resp_n = 0; got = 1'b0;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = v.we;
    wbs_adr_i = v.adr; wbs_dat_i = v.wdat; wbs_sel_i = v.sel;
    if (v.abort_n == 0) sb_q.push_back('{v.exp_ack, v.exp_err, v.exp_dat});
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (wbs_ack_o || wbs_err_o) begin
        got = 1'b1;
        resp_n = n;
      end
      if (avm_read_o || avm_write_o) begin
        k++;
        check_eq("cmd_dir", 32'(avm_write_o), 32'(v.we));
        check_eq("cmd_addr", avm_address_o, v.adr);
        check_eq("cmd_be", 32'(avm_byteenable_o), 32'(v.sel));
        check_eq("cmd_wdata", avm_writedata_o, v.wdat);
        avm_waitrequest_i = (k <= v.wait_n);
        if (!avm_waitrequest_i && !v.we) since = 0;
      end else if (since >= 0) begin
        since++;
      end
      avm_readdatavalid_i = !v.we && (since == v.rdv_d);
      avm_readdata_i = avm_readdatavalid_i ? v.rdata : $urandom();
      if (n == v.abort_n) begin
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      end
      if (got) begin
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        break;
      end
      if (v.abort_n != 0 && n > v.exp_lat) break;
    end
    check_eq("resp_seen", 32'(got), 32'(v.abort_n == 0));
    if (v.abort_n == 0) check_eq("resp_latency", 32'(resp_n), 32'(v.exp_lat));
    check_eq("cmd_cycles", 32'(k), 32'(v.exp_k));
    @(negedge clk);
    avm_readdatavalid_i = 1'b0;
    avm_waitrequest_i = 1'b0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    check_eq("back_idle", {28'd0, avm_read_o, avm_write_o, wbs_ack_o, wbs_err_o}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           we  adr       wdat          sel  wt  rd  rdata         ab ack err exp_dat      lat k
    vecs[0]  = '{1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 0,  0, 32'h0,         0, 1'b1, 1'b0, 32'h0,        2, 1};
    vecs[1]  = '{1'b0, 32'h200, 32'h0,        4'hF, 3,  2, 32'h12345678,  0, 1'b1, 1'b0, 32'h12345678, 7, 4};
    vecs[2]  = '{1'b0, 32'h204, 32'h0,        4'hF, 0,  0, 32'hA5A5A5A5,  0, 1'b1, 1'b0, 32'hA5A5A5A5, 2, 1};
    vecs[3]  = '{1'b1, 32'h300, 32'h0000CAFE, 4'h3, 2,  0, 32'h0,         0, 1'b1, 1'b0, 32'hA5A5A5A5, 4, 3};
    vecs[4]  = '{1'b0, 32'h400, 32'h0,        4'hF, 99, 0, 32'h0,         0, 1'b0, 1'b1, 32'hA5A5A5A5, 17, 16};
    vecs[5]  = '{1'b1, 32'h500, 32'h77777777, 4'hC, 99, 0, 32'h0,         0, 1'b0, 1'b1, 32'hA5A5A5A5, 17, 16};
    vecs[6]  = '{1'b0, 32'h600, 32'h0,        4'hF, 15, 0, 32'h13572468,  0, 1'b1, 1'b0, 32'h13572468, 17, 16};
    vecs[7]  = '{1'b1, 32'h700, 32'h89ABCDEF, 4'hF, 15, 0, 32'h0,         0, 1'b1, 1'b0, 32'h13572468, 17, 16};
    vecs[8]  = '{1'b0, 32'h800, 32'h0,        4'h6, 1,  5, 32'h0F0F0F0F,  0, 1'b1, 1'b0, 32'h0F0F0F0F, 8, 2};
    vecs[9]  = '{1'b0, 32'h900, 32'h0,        4'hF, 0, 15, 32'h11223344,  0, 1'b1, 1'b0, 32'h11223344, 17, 1};
    vecs[10] = '{1'b0, 32'hA00, 32'h0,        4'hF, 0, 16, 32'hBAD0BAD0,  0, 1'b0, 1'b1, 32'h11223344, 17, 1};
    vecs[11] = '{1'b0, 32'hB00, 32'h0,        4'hF, 0,  4, 32'h55AA55AA,  2, 1'b0, 1'b0, 32'h0,        6, 1};
    vecs[12] = '{1'b1, 32'hC00, 32'h01020304, 4'h1, 0,  0, 32'h0,         0, 1'b1, 1'b0, 32'h55AA55AA, 2, 1};
    vpost    = '{1'b0, 32'hE00, 32'h0,        4'hF, 1,  1, 32'hCAFEF00D,  0, 1'b1, 1'b0, 32'hCAFEF00D, 4, 2};

    rst = 1'b1;
    wbs_adr_i = '0; wbs_dat_i = '0; wbs_sel_i = '0; wbs_we_i = 1'b0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_cti_i = 3'd0; wbs_bte_i = 2'd0;
    avm_readdata_i = '0; avm_waitrequest_i = 1'b0; avm_readdatavalid_i = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_flags", {28'd0, avm_read_o, avm_write_o, wbs_ack_o, wbs_err_o}, 32'd0);
    check_eq("rst_dat", wbs_dat_o, 32'd0);
    check_eq("rst_addr", avm_address_o, 32'd0);
    check_eq("rst_wdata", avm_writedata_o, 32'd0);
    check_eq("rst_be", 32'(avm_byteenable_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rty_const", 32'(wbs_rty_o), 32'd0);
    check_eq("burst_const", 32'(avm_burstcount_o), 32'd1);

    for (int i = 0; i < 13; i++) run_txn(vecs[i]);

    // Stray readdatavalid while idle must not disturb the held read data.
    avm_readdatavalid_i = 1'b1;
    avm_readdata_i = 32'hFFFF0000;
    repeat (2) @(negedge clk);
    avm_readdatavalid_i = 1'b0;
    @(negedge clk);
    check_eq("stray_rdv_dat", wbs_dat_o, 32'h55AA55AA);

    // Reset in the middle of a stalled write.
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = 32'hD00; wbs_dat_i = 32'h600DF00D; wbs_sel_i = 4'hF;
    avm_waitrequest_i = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("pre_rst_write", 32'(avm_write_o), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("rst_write_drop", 32'(avm_write_o), 32'd0);
    check_eq("rst_no_ack", {30'd0, wbs_ack_o, wbs_err_o}, 32'd0);
    check_eq("rst_addr_clear", avm_address_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    avm_waitrequest_i = 1'b0;
    @(negedge clk);
    check_eq("rst_dat_clear", wbs_dat_o, 32'd0);
    run_txn(vpost);

    repeat (2) @(negedge clk);
    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
